// File: rtl/drum_pkg.sv
// Shared definitions for the drum voice blocks: bar geometry, player states and tempo floor.
package drum_pkg;

   localparam int unsigned STEPS          = 8;
   localparam int unsigned STEP_W         = $clog2(STEPS);
   localparam int unsigned MIN_PERIOD_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } player_state_t;

endpackage

// File: rtl/gate_timer.sv
// Retriggerable down-counter: a load pulse starts a gate of len cycles, beginning in the load cycle.
module gate_timer #(
   parameter int unsigned LEN_W = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             gate_o
);

   logic [LEN_W-1:0] count_q, count_d;
   logic             gate_q;

   // Clear beats load so a stop always silences the voice.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = len_i;
      end else if (count_q != '0) begin
         count_d = count_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         gate_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         gate_q  <= (count_d != '0);
      end
   end

   assign gate_o = gate_q;

endmodule

// File: rtl/pattern_player.sv
// Plays an 8-step pattern at a programmable tempo: beat square wave, per-step hit trigger and gate.
module pattern_player
   import drum_pkg::*;
#(
   parameter int unsigned PER_W       = 26,
   parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF,
   parameter int unsigned GATE_CYCLES = 1000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              restart,
   input  logic [PER_W-1:0]  step_period,
   input  logic [STEPS-1:0]  seq,
   output logic              beat,
   output logic [STEP_W-1:0] step_idx,
   output logic              trig,
   output logic              gate,
   output logic              playing
);

   localparam int unsigned       GATE_W    = $clog2(GATE_CYCLES + 1);
   localparam logic [PER_W-1:0]  MIN_P     = PER_W'(MIN_PERIOD);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   player_state_t     state_q, state_d;
   logic [PER_W-1:0]  phase_q, phase_d;
   logic [PER_W-1:0]  period_q, period_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              beat_q, beat_d;
   logic              trig_q, trig_d;
   logic              playing_q, playing_d;
   logic [PER_W-1:0]  clamped;
   logic [STEP_W-1:0] next_step;
   logic              start;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         period_q  <= MIN_P;
         step_q    <= LAST_STEP;
         beat_q    <= 1'b0;
         trig_q    <= 1'b0;
         playing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         period_q  <= period_d;
         step_q    <= step_d;
         beat_q    <= beat_d;
         trig_q    <= trig_d;
         playing_q <= playing_d;
      end
   end

   // Registers hold the values of the cycle being entered, so a step start shows phase 0, beat high
   // and the sampled hit together.
   always_comb begin
      clamped   = (step_period < MIN_P) ? MIN_P : step_period;
      state_d   = state_q;
      phase_d   = phase_q;
      period_d  = period_q;
      step_d    = step_q;
      beat_d    = beat_q;
      trig_d    = 1'b0;
      playing_d = playing_q;
      start     = 1'b0;
      next_step = step_q;
      case (state_q)
         IDLE: begin
            if (run) begin
               state_d   = PLAY;
               start     = 1'b1;
               next_step = LAST_STEP;
            end
         end
         PLAY: begin
            if (!run) begin
               state_d   = IDLE;
               phase_d   = '0;
               step_d    = LAST_STEP;
               beat_d    = 1'b0;
               playing_d = 1'b0;
            end else if (restart) begin
               start     = 1'b1;
               next_step = LAST_STEP;
            end else if (phase_q == period_q - PER_W'(1)) begin
               start     = 1'b1;
               next_step = step_q - STEP_W'(1);
            end else begin
               phase_d = phase_q + PER_W'(1);
               beat_d  = (phase_d < (period_q >> 1));
            end
         end
      endcase
      // Tempo and pattern are only sampled here, so mid-step edits land on the next step.
      if (start) begin
         phase_d   = '0;
         period_d  = clamped;
         step_d    = next_step;
         beat_d    = ((clamped >> 1) != '0);
         trig_d    = seq[next_step];
         playing_d = 1'b1;
      end
   end

   gate_timer #(
      .LEN_W (GATE_W)
   ) u_gate_timer (
      .clock   (clock),
      .reset   (reset),
      .clear_i (state_d == IDLE),
      .load_i  (trig_d),
      .len_i   (GATE_W'(GATE_CYCLES)),
      .gate_o  (gate)
   );

   assign beat     = beat_q;
   assign step_idx = step_q;
   assign trig     = trig_q;
   assign playing  = playing_q;

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: timeline model of bar/step/gate timing checked every cycle plus literal checks.
module tb_pattern_player;

   localparam int G = 15;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        restart = 1'b0;
   logic [25:0] step_period = 26'd10;
   logic [7:0]  seq = 8'h81;
   logic        beat, trig, gate, playing;
   logic [2:0]  step_idx;

   int checks = 0;
   int failures = 0;

   // Model: where we are in the bar, expressed as step number and cycles into the step.
   bit m_play = 1'b0;
   int m_idx = 7;
   int m_phase = 0;
   int m_per = 4;
   bit m_hit = 1'b0;
   bit m_started = 1'b0;
   int m_last = -100000;
   int cyc = 0;

   int n_trig = 0, n_gate = 0, n_beat = 0, n_trig5 = 0;
   int b_trig = 0, b_gate = 0, b_beat = 0, b_trig5 = 0;

   pattern_player #(
      .PER_W       (26),
      .MIN_PERIOD  (4),
      .GATE_CYCLES (G)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .restart     (restart),
      .step_period (step_period),
      .seq         (seq),
      .beat        (beat),
      .step_idx    (step_idx),
      .trig        (trig),
      .gate        (gate),
      .playing     (playing)
   );

   always #5 clock = ~clock;

   task automatic step_start(input int i);
      m_idx     = i;
      m_phase   = 0;
      m_per     = (step_period < 26'd4) ? 4 : int'(step_period);
      m_hit     = seq[i];
      m_started = 1'b1;
      if (m_hit) m_last = cyc;
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_play = 1'b0; m_idx = 7; m_phase = 0; m_per = 4;
         m_hit = 1'b0; m_started = 1'b0; m_last = -100000;
      end else begin
         cyc++;
         m_started = 1'b0;
         if (!m_play) begin
            if (run) begin
               m_play = 1'b1;
               step_start(7);
            end
         end else if (!run) begin
            m_play = 1'b0; m_idx = 7; m_phase = 0; m_last = -100000;
         end else if (restart) begin
            step_start(7);
         end else if (m_phase == m_per - 1) begin
            step_start((m_idx + 7) % 8);
         end else begin
            m_phase++;
         end
      end
   end

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all outputs against the model on every cycle, then tally activity.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         cmp("beat", int'(beat), (m_play && (m_phase < m_per / 2)) ? 1 : 0);
         cmp("step_idx", int'(step_idx), m_idx);
         cmp("trig", int'(trig), (m_play && m_started && m_hit) ? 1 : 0);
         cmp("gate", int'(gate), (m_play && ((cyc - m_last) < G)) ? 1 : 0);
         cmp("playing", int'(playing), m_play ? 1 : 0);
         n_trig += int'(trig);
         n_gate += int'(gate);
         n_beat += int'(beat);
         if (trig && step_idx == 3'd5) n_trig5++;
         #1;
      end
   endtask

   task automatic snap();
      b_trig = n_trig; b_gate = n_gate; b_beat = n_beat; b_trig5 = n_trig5;
   endtask

   task automatic start_fresh(input int per, input logic [7:0] s);
      run = 1'b0;
      tick(2);
      step_period = 26'(per);
      seq = s;
      run = 1'b1;
      snap();
   endtask

   task automatic check_idle(input string tag);
      cmp({tag, "_idx"}, int'(step_idx), 7);
      cmp({tag, "_beat"}, int'(beat), 0);
      cmp({tag, "_trig"}, int'(trig), 0);
      cmp({tag, "_gate"}, int'(gate), 0);
      cmp({tag, "_playing"}, int'(playing), 0);
   endtask

   initial begin
      #1 reset = 1'b0;
      tick(3);
      check_idle("reset");
      reset = 1'b1;
      tick(2);

      // Basic loop: 2 bars of 8 x 10 cycles, hits on steps 7 and 0.
      start_fresh(10, 8'h81);
      tick(1);
      cmp("first_idx", int'(step_idx), 7);
      cmp("first_trig", int'(trig), 1);
      cmp("first_beat", int'(beat), 1);
      tick(159);
      cmp("loop_trigs", n_trig - b_trig, 4);
      cmp("loop_beat_high", n_beat - b_beat, 80);
      cmp("loop_gate_high", n_gate - b_gate, 50);
      cmp("loop_end_idx", int'(step_idx), 0);

      // Period below the floor plays as 4; odd period splits 3 high / 4 low.
      start_fresh(2, 8'h81);
      tick(32);
      cmp("clamp_trigs", n_trig - b_trig, 2);
      cmp("clamp_beat_high", n_beat - b_beat, 16);
      cmp("clamp_gate_high", n_gate - b_gate, 19);
      cmp("clamp_end_idx", int'(step_idx), 0);
      start_fresh(7, 8'h81);
      tick(56);
      cmp("odd_trigs", n_trig - b_trig, 2);
      cmp("odd_beat_high", n_beat - b_beat, 24);
      cmp("odd_gate_high", n_gate - b_gate, 22);

      // Edits during step 5 only take effect at later step starts.
      start_fresh(10, 8'h81);
      tick(23);
      cmp("edit_at_step5", int'(step_idx), 5);
      seq = 8'hA1;
      step_period = 26'd20;
      snap();
      tick(7);
      cmp("edit_step5_holds", int'(step_idx), 5);
      tick(1);
      cmp("edit_step4_start", int'(step_idx), 4);
      tick(19);
      cmp("edit_step4_long", int'(step_idx), 4);
      tick(1);
      cmp("edit_step3_start", int'(step_idx), 3);
      tick(120);
      cmp("edit_next_bar_idx", int'(step_idx), 5);
      cmp("edit_next_bar_trig", int'(trig), 1);
      cmp("edit_trig5_count", n_trig5 - b_trig5, 1);

      // Restart mid-step jumps to step 7; stop beats a coincident restart.
      start_fresh(10, 8'h81);
      tick(47);
      cmp("rst_before_idx", int'(step_idx), 3);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      cmp("restart_idx", int'(step_idx), 7);
      cmp("restart_trig", int'(trig), 1);
      cmp("restart_beat", int'(beat), 1);
      tick(10);
      cmp("restart_next_idx", int'(step_idx), 6);
      cmp("restart_gate_on", int'(gate), 1);
      run = 1'b0;
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      cmp("stop_playing", int'(playing), 0);
      cmp("stop_gate", int'(gate), 0);
      cmp("stop_idx", int'(step_idx), 7);
      tick(3);
      cmp("stop_stays_idle", int'(playing), 0);

      // Gate longer than a step holds high under dense hits; single hit gives 15 per bar.
      start_fresh(10, 8'hFF);
      tick(80);
      cmp("dense_gate_high", n_gate - b_gate, 80);
      cmp("dense_trigs", n_trig - b_trig, 8);
      start_fresh(10, 8'h01);
      tick(170);
      cmp("sparse_gate_high", n_gate - b_gate, 30);
      cmp("sparse_trigs", n_trig - b_trig, 2);

      // Asynchronous reset mid-play clears outputs without waiting for an edge.
      start_fresh(10, 8'hFF);
      tick(5);
      cmp("pre_reset_gate", int'(gate), 1);
      cmp("pre_reset_playing", int'(playing), 1);
      reset = 1'b0;
      #1;
      check_idle("async_reset");
      tick(2);
      run = 1'b0;
      reset = 1'b1;
      tick(3);
      cmp("post_reset_playing", int'(playing), 0);
      cmp("post_reset_idx", int'(step_idx), 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
